// File: rtl/rsa_keygen_engine_pkg.sv
// Shared definitions for the RSA key-pair engine: FSM state encoding and
// default parameter values.
package rsa_keygen_engine_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PHI,
        ST_INIT,
        ST_DIV,
        ST_UPDATE,
        ST_CHECK,
        ST_FIXUP,
        ST_FAIL,
        ST_DONE
    } state_e;

    localparam int WIDTH_DEFAULT   = 32;
    localparam int E_FLOOR_DEFAULT = 3;

endpackage

// File: rtl/rsa_keygen_engine_if.sv
// Request/response bundle between the prime source and the key-pair engine.
// p and q are WIDTH bits; exponents are 2*WIDTH bits.
interface rsa_keygen_engine_if
    import rsa_keygen_engine_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);

    logic                 start;
    logic                 mode;
    logic [WIDTH-1:0]     p;
    logic [WIDTH-1:0]     q;
    logic [2*WIDTH-1:0]   e_init;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic [2*WIDTH-1:0]   e;
    logic [2*WIDTH-1:0]   d;

    modport master (
        output start, mode, p, q, e_init,
        input  busy, done, error, e, d
    );

    modport slave (
        input  start, mode, p, q, e_init,
        output busy, done, error, e, d
    );

endinterface

// File: rtl/rsa_keygen_engine_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; done pulses W cycles
// after start. A zero divisor yields quot = all-ones and rem = dividend.
module seq_divider #(
    parameter int W = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] quot_o,
    output logic [W-1:0] rem_o,
    output logic         done_o
);
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  quot_q, quot_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  dvsr_q, dvsr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d;
    logic          done_q, done_d;
    logic [W:0]    trial;

    always_comb begin
        quot_d = quot_q;
        rem_d  = rem_q;
        dvsr_d = dvsr_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;
        // quot_q doubles as the dividend shift register: its MSB feeds the remainder.
        trial  = {rem_q, quot_q[W-1]};
        if (start_i) begin
            quot_d = dividend_i;
            rem_d  = '0;
            dvsr_d = divisor_i;
            cnt_d  = CW'(W);
            run_d  = 1'b1;
        end else if (run_q) begin
            if (trial >= {1'b0, dvsr_q}) begin
                rem_d  = W'(trial - {1'b0, dvsr_q});
                quot_d = {quot_q[W-2:0], 1'b1};
            end else begin
                rem_d  = trial[W-1:0];
                quot_d = {quot_q[W-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            quot_q <= '0;
            rem_q  <= '0;
            dvsr_q <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dvsr_q <= dvsr_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign quot_o = quot_q;
    assign rem_o  = rem_q;
    assign done_o = done_q;

endmodule

// File: rtl/rsa_keygen_engine.sv
// RSA key-pair engine: phi = (p-1)(q-1), pick e (fixed or odd upward search),
// d = e^-1 mod phi via iterative extended Euclid on a multi-cycle divider.
module rsa_keygen_engine
    import rsa_keygen_engine_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEFAULT,
    parameter int E_FLOOR = E_FLOOR_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_i,
    rsa_keygen_engine_if.slave kg_if
);
    localparam int NW = 2 * WIDTH;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   p_q, p_d, q_q, q_d;
    logic               mode_q, mode_d;
    logic [NW-1:0]      einit_q, einit_d;
    logic [NW-1:0]      phi_q, phi_d;
    logic [NW-1:0]      cand_q, cand_d;
    logic [NW-1:0]      a_q, a_d, b_q, b_d;
    logic [NW-1:0]      e_q, e_d, d_q, d_d;
    logic signed [NW:0] y_q, y_d, yp_q, yp_d;
    logic               err_q, err_d;

    logic               div_start;
    logic [NW-1:0]      div_dividend, div_divisor;
    logic [NW-1:0]      div_quot, div_rem;
    logic               div_done;

    logic [NW-1:0]      phi_c, cand_floor, cand_c, yp_fix;
    logic [NW:0]        cand_inc;
    logic signed [NW:0] qy_prod;

    assign phi_c      = {{WIDTH{1'b0}}, p_q - WIDTH'(1)} * {{WIDTH{1'b0}}, q_q - WIDTH'(1)};
    assign cand_floor = (einit_q < NW'(E_FLOOR)) ? NW'(E_FLOOR) : einit_q;
    assign cand_c     = (!mode_q && !cand_floor[0]) ? cand_floor + NW'(1) : cand_floor;
    assign cand_inc   = {1'b0, cand_q} + (NW + 1)'(2);
    assign qy_prod    = $signed({1'b0, div_quot}) * y_q;
    // Result lies in 1..phi-1, so modular addition on the low bits is exact.
    assign yp_fix     = phi_q + yp_q[NW-1:0];

    seq_divider #(.W(NW)) u_div (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (div_start),
        .dividend_i (div_dividend),
        .divisor_i  (div_divisor),
        .quot_o     (div_quot),
        .rem_o      (div_rem),
        .done_o     (div_done)
    );

    always_comb begin
        state_d      = state_q;
        p_d          = p_q;
        q_d          = q_q;
        mode_d       = mode_q;
        einit_d      = einit_q;
        phi_d        = phi_q;
        cand_d       = cand_q;
        a_d          = a_q;
        b_d          = b_q;
        y_d          = y_q;
        yp_d         = yp_q;
        e_d          = e_q;
        d_d          = d_q;
        err_d        = err_q;
        div_start    = 1'b0;
        div_dividend = b_q;
        div_divisor  = div_rem;
        unique case (state_q)
            ST_IDLE: begin
                if (kg_if.start) begin
                    p_d     = kg_if.p;
                    q_d     = kg_if.q;
                    mode_d  = kg_if.mode;
                    einit_d = kg_if.e_init;
                    state_d = ST_PHI;
                end
            end
            ST_PHI: begin
                phi_d  = phi_c;
                cand_d = cand_c;
                if (p_q < WIDTH'(2) || q_q < WIDTH'(2) || phi_c < NW'(2) || cand_c >= phi_c)
                    state_d = ST_FAIL;
                else
                    state_d = ST_INIT;
            end
            ST_INIT: begin
                a_d          = phi_q;
                b_d          = cand_q;
                y_d          = {{NW{1'b0}}, 1'b1};
                yp_d         = '0;
                div_start    = 1'b1;
                div_dividend = phi_q;
                div_divisor  = cand_q;
                state_d      = ST_DIV;
            end
            ST_DIV: begin
                if (div_done)
                    state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                // y tracks b's coefficient of e, yp tracks a's.
                a_d  = b_q;
                b_d  = div_rem;
                y_d  = yp_q - qy_prod;
                yp_d = y_q;
                if (div_rem != '0) begin
                    div_start = 1'b1;
                    state_d   = ST_DIV;
                end else begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (a_q == NW'(1)) begin
                    state_d = ST_FIXUP;
                end else if (mode_q) begin
                    state_d = ST_FAIL;
                end else if (cand_inc[NW] || cand_inc[NW-1:0] >= phi_q) begin
                    state_d = ST_FAIL;
                end else begin
                    cand_d  = cand_inc[NW-1:0];
                    state_d = ST_INIT;
                end
            end
            ST_FIXUP: begin
                d_d     = yp_q[NW] ? yp_fix : yp_q[NW-1:0];
                e_d     = cand_q;
                err_d   = 1'b0;
                state_d = ST_DONE;
            end
            ST_FAIL: begin
                e_d     = '0;
                d_d     = '0;
                err_d   = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            p_q     <= '0;
            q_q     <= '0;
            mode_q  <= 1'b0;
            einit_q <= '0;
            phi_q   <= '0;
            cand_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
            yp_q    <= '0;
            e_q     <= '0;
            d_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            q_q     <= q_d;
            mode_q  <= mode_d;
            einit_q <= einit_d;
            phi_q   <= phi_d;
            cand_q  <= cand_d;
            a_q     <= a_d;
            b_q     <= b_d;
            y_q     <= y_d;
            yp_q    <= yp_d;
            e_q     <= e_d;
            d_q     <= d_d;
            err_q   <= err_d;
        end
    end

    assign kg_if.busy  = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign kg_if.done  = (state_q == ST_DONE);
    assign kg_if.error = err_q;
    assign kg_if.e     = e_q;
    assign kg_if.d     = d_q;

endmodule

// File: tb/tb_rsa_keygen_engine.sv
// Directed and randomized checks of rsa_keygen_engine against an arithmetic
// reference model of RSA key derivation.
module tb_rsa_keygen_engine;
    localparam int WIDTH = 16;
    localparam int NW    = 2 * WIDTH;
    localparam int LIMIT = 20000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    rsa_keygen_engine_if #(.WIDTH(WIDTH)) kg_if ();

    rsa_keygen_engine #(.WIDTH(WIDTH), .E_FLOOR(3)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .kg_if (kg_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint gcd(input longint x, input longint y);
        longint t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic longint modinv(input longint ev, input longint phi);
        longint t = 0, nt = 1, r = phi, nr = ev, qt, tmp;
        while (nr != 0) begin
            qt  = r / nr;
            tmp = t - qt * nt; t = nt; nt = tmp;
            tmp = r - qt * nr; r = nr; nr = tmp;
        end
        if (t < 0) t = t + phi;
        return t;
    endfunction

    task automatic model(input longint p, input longint q, input bit mode, input longint ei,
                         output longint xe, output longint xd, output bit xerr);
        longint phi, cand;
        xe = 0; xd = 0; xerr = 1'b1;
        if (p < 2 || q < 2) return;
        phi = (p - 1) * (q - 1);
        if (phi < 2) return;
        cand = (ei < 3) ? 3 : ei;
        if (!mode && (cand % 2 == 0)) cand = cand + 1;
        while (cand < phi) begin
            if (gcd(cand, phi) == 1) begin
                xe = cand; xd = modinv(cand, phi); xerr = 1'b0;
                return;
            end
            if (mode) return;
            cand = cand + 2;
        end
    endtask

    task automatic pulse_start(input longint p, input longint q, input bit mode, input longint ei);
        @(negedge clk);
        kg_if.p      = WIDTH'(p);
        kg_if.q      = WIDTH'(q);
        kg_if.mode   = mode;
        kg_if.e_init = NW'(ei);
        kg_if.start  = 1'b1;
        @(negedge clk);
        kg_if.start  = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int cycles);
        cycles = 0;
        while (kg_if.done !== 1'b1 && cycles < LIMIT) begin
            @(negedge clk);
            cycles++;
        end
        check({tag, "_done_seen"}, 64'(kg_if.done), 64'd1);
    endtask

    task automatic run_and_check(input string tag, input longint p, input longint q, input bit mode,
                                 input longint ei, input longint xe, input longint xd, input bit xerr,
                                 output int cycles);
        pulse_start(p, q, mode, ei);
        check({tag, "_busy"}, 64'(kg_if.busy), 64'd1);
        wait_done(tag, cycles);
        $display("op %s p=%0d q=%0d mode=%0d e_init=%0d -> e=%0d d=%0d err=%0d cycles=%0d",
                 tag, p, q, mode, ei, kg_if.e, kg_if.d, kg_if.error, cycles);
        check({tag, "_e"}, 64'(kg_if.e), 64'(xe));
        check({tag, "_d"}, 64'(kg_if.d), 64'(xd));
        check({tag, "_err"}, 64'(kg_if.error), 64'(xerr));
        check({tag, "_busy_at_done"}, 64'(kg_if.busy), 64'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(kg_if.done), 64'd0);
    endtask

    initial begin
        int     cyc;
        int     extra_done;
        longint rp, rq, rei, xe, xd;
        bit     rmode, xerr;

        kg_if.start = 1'b0; kg_if.mode = 1'b0;
        kg_if.p = '0; kg_if.q = '0; kg_if.e_init = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(kg_if.busy), 64'd0);
        check("rst_done", 64'(kg_if.done), 64'd0);
        check("rst_err", 64'(kg_if.error), 64'd0);
        check("rst_e", 64'(kg_if.e), 64'd0);
        check("rst_d", 64'(kg_if.d), 64'd0);
        rst = 1'b0;

        run_and_check("search_e7", 61, 53, 1'b0, 3, 7, 1783, 1'b0, cyc);
        run_and_check("fixed_e17", 61, 53, 1'b1, 17, 17, 2753, 1'b0, cyc);
        run_and_check("fixed_e15", 61, 53, 1'b1, 15, 0, 0, 1'b1, cyc);
        run_and_check("even_round", 3, 5, 1'b0, 4, 5, 5, 1'b0, cyc);
        run_and_check("phi2_fail", 2, 3, 1'b0, 3, 0, 0, 1'b1, cyc);
        run_and_check("p1_fail", 1, 53, 1'b0, 3, 0, 0, 1'b1, cyc);
        check("p1_latency", 64'(cyc), 64'd2);

        // Second start while busy must be dropped entirely.
        pulse_start(61, 53, 1'b1, 17);
        repeat (5) @(negedge clk);
        kg_if.p = WIDTH'(3); kg_if.q = WIDTH'(5); kg_if.mode = 1'b0; kg_if.e_init = NW'(4);
        kg_if.start = 1'b1;
        @(negedge clk);
        kg_if.start = 1'b0;
        wait_done("ignored", cyc);
        $display("op ignored_start e=%0d d=%0d err=%0d cycles=%0d", kg_if.e, kg_if.d, kg_if.error, cyc);
        check("ignored_e", 64'(kg_if.e), 64'd17);
        check("ignored_d", 64'(kg_if.d), 64'd2753);
        extra_done = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (kg_if.done === 1'b1) extra_done++;
        end
        check("ignored_no_second_done", 64'(extra_done), 64'd0);

        // Asynchronous reset while the divider is running.
        pulse_start(61, 53, 1'b0, 3);
        repeat (10) @(negedge clk);
        check("middiv_busy", 64'(kg_if.busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 64'(kg_if.busy), 64'd0);
        check("arst_done", 64'(kg_if.done), 64'd0);
        check("arst_err", 64'(kg_if.error), 64'd0);
        check("arst_e", 64'(kg_if.e), 64'd0);
        check("arst_d", 64'(kg_if.d), 64'd0);
        @(negedge clk);
        kg_if.start = 1'b1;
        @(negedge clk);
        kg_if.start = 1'b0;
        check("start_in_reset_busy", 64'(kg_if.busy), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("after_reset_idle", 64'(kg_if.busy), 64'd0);
        $display("op reset_mid_div busy=%0d e=%0d d=%0d", kg_if.busy, kg_if.e, kg_if.d);
        run_and_check("post_reset", 2, 7, 1'b0, 3, 5, 5, 1'b0, cyc);

        for (int i = 0; i < 12; i++) begin
            rp    = longint'($urandom_range(0, 2000));
            rq    = longint'($urandom_range(0, 2000));
            rmode = 1'($urandom_range(0, 1));
            rei   = ($urandom_range(0, 3) == 0) ? longint'($urandom) : longint'($urandom_range(0, 40));
            model(rp, rq, rmode, rei, xe, xd, xerr);
            run_and_check($sformatf("rand%0d", i), rp, rq, rmode, rei, xe, xd, xerr, cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
